// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
// slave is the unit itself; master is the datapath plus memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed,
    input  req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_signed,
    output req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: byte/half/word loads and stores to a
// big-endian word memory; sub-word stores are read-modify-write.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 64
) (
  input logic              CLK,
  input logic              Reset,
  load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, LOAD, RMW, WRITE, RESP
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        sgn_q;
  logic [15:0] wlo_q;

  logic        acc;
  logic        mis;
  logic        err;
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic [7:0]  b8;
  logic [15:0] h16;
  logic [31:0] ld_data;
  logic [31:0] st_mask;
  logic [31:0] st_data;
  logic [31:0] merged;

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign acc = bus.req_valid && (state == IDLE);

  always_comb begin
    nbytes = 3'd4;
    mis    = 1'b0;
    unique case (1'b1)
      bus.req_size == 2'b00: nbytes = 3'd1;
      bus.req_size == 2'b01: begin
        nbytes = 3'd2;
        mis    = bus.req_addr[0];
      end
      bus.req_size == 2'b10: mis = |bus.req_addr[1:0];
      default:               mis = 1'b1;
    endcase
  end

  // 33-bit sum so addresses near 2^32 cannot wrap into range
  assign end_addr = {1'b0, bus.req_addr} + {30'd0, nbytes};
  assign err = mis || (end_addr > 33'(MEM_BYTES));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (acc) begin
        if (err)                        state_nx = RESP;
        else if (!bus.req_we)           state_nx = LOAD;
        else if (bus.req_size == 2'b10) state_nx = WRITE;
        else                            state_nx = RMW;
      end
      LOAD:    state_nx = RESP;
      RMW:     state_nx = WRITE;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    b8 = bus.mem_rdata[31:24];
    unique case (off_q)
      2'd0: b8 = bus.mem_rdata[31:24];
      2'd1: b8 = bus.mem_rdata[23:16];
      2'd2: b8 = bus.mem_rdata[15:8];
      2'd3: b8 = bus.mem_rdata[7:0];
    endcase
    h16 = off_q[1] ? bus.mem_rdata[15:0]
                   : bus.mem_rdata[31:16];
  end

  always_comb begin
    ld_data = bus.mem_rdata;
    if (size_q == 2'b00)
      ld_data = {{24{sgn_q & b8[7]}}, b8};
    else if (size_q == 2'b01)
      ld_data = {{16{sgn_q & h16[15]}}, h16};
  end

  always_comb begin
    st_data = {2{wlo_q}};
    st_mask = off_q[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
    if (size_q == 2'b00) begin
      st_data = {4{wlo_q[7:0]}};
      st_mask = 32'hFF00_0000 >> {off_q, 3'b000};
    end
    merged = (bus.mem_rdata & ~st_mask) | (st_data & st_mask);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      size_q         <= 2'b00;
      off_q          <= 2'b00;
      sgn_q          <= 1'b0;
      wlo_q          <= 16'd0;
      bus.mem_addr   <= 32'd0;
      bus.mem_wdata  <= 32'd0;
      bus.mem_we     <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
    end else begin
      // registered so the negedge write sees a clean strobe
      bus.mem_we <= (state_nx == WRITE);
      unique case (state)
        IDLE: if (acc) begin
          size_q <= bus.req_size;
          off_q  <= bus.req_addr[1:0];
          sgn_q  <= bus.req_signed;
          wlo_q  <= bus.req_wdata[15:0];
          if (err) begin
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= 32'd0;
          end else begin
            bus.mem_addr <= {bus.req_addr[31:2], 2'b00};
            if (bus.req_we && bus.req_size == 2'b10)
              bus.mem_wdata <= bus.req_wdata;
          end
        end
        LOAD: begin
          bus.resp_rdata <= ld_data;
          bus.resp_err   <= 1'b0;
        end
        RMW: bus.mem_wdata <= merged;
        WRITE: begin
          bus.resp_rdata <= 32'd0;
          bus.resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 16-word memory model.
// Vector table plus hand sequences for hold and mid-op reset.
module tb_load_store_unit;
  logic CLK = 1'b0;
  logic Reset = 1'b0;
  logic preload = 1'b1;
  always #5 CLK = ~CLK;

  load_store_unit_if bus();
  load_store_unit #(.MEM_BYTES(64)) dut (
    .CLK(CLK), .Reset(Reset), .bus(bus)
  );

  logic [31:0] mem [16];
  assign bus.mem_rdata = mem[bus.mem_addr[5:2]];

  always @(negedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem[2]  <= 32'h80FF_1234;
      mem[15] <= 32'hCAFE_F00D;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, " ready"}, {31'd0, bus.req_ready}, 32'd1);
    chk({nm, " rvalid"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({nm, " rdata"}, bus.resp_rdata, 32'd0);
    chk({nm, " rerr"}, {31'd0, bus.resp_err}, 32'd0);
    chk({nm, " mwe"}, {31'd0, bus.mem_we}, 32'd0);
    chk({nm, " maddr"}, bus.mem_addr, 32'd0);
    chk({nm, " mwdata"}, bus.mem_wdata, 32'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("ready wait", {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic drive(input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd);
    wait_ready();
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic xact(input logic we, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a,
                      input logic [31:0] wd,
                      output logic [31:0] rd, output logic er,
                      output int lat, output int wec);
    drive(we, sz, sg, a, wd);
    lat = 1;
    wec = 0;
    while (!bus.resp_valid && lat < 8) begin
      wec += int'(bus.mem_we);
      @(posedge CLK); #1;
      lat++;
    end
    wec += int'(bus.mem_we);
    rd = bus.resp_rdata;
    er = bus.resp_err;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          idx;
    logic [31:0] mw;
  } vec_t;

  vec_t v[19];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wec;

    v[0]  = '{0, 2'd0, 1, 9,  0, 32'hFFFF_FFFF, 0, 2, 2,  32'h80FF_1234};
    v[1]  = '{0, 2'd0, 0, 9,  0, 32'h0000_00FF, 0, 2, 2,  32'h80FF_1234};
    v[2]  = '{0, 2'd1, 0, 10, 0, 32'h0000_1234, 0, 2, 2,  32'h80FF_1234};
    v[3]  = '{0, 2'd1, 1, 8,  0, 32'hFFFF_80FF, 0, 2, 2,  32'h80FF_1234};
    v[4]  = '{0, 2'd0, 1, 8,  0, 32'hFFFF_FF80, 0, 2, 2,  32'h80FF_1234};
    v[5]  = '{0, 2'd0, 0, 11, 0, 32'h0000_0034, 0, 2, 2,  32'h80FF_1234};
    v[6]  = '{0, 2'd2, 0, 8,  0, 32'h80FF_1234, 0, 2, 2,  32'h80FF_1234};
    v[7]  = '{1, 2'd0, 0, 10, 32'hAA, 0, 0, 3, 2, 32'h80FF_AA34};
    v[8]  = '{1, 2'd2, 0, 6, 32'hDEAD_BEEF, 0, 1, 1, 1, 32'd0};
    v[9]  = '{0, 2'd2, 0, 60, 0, 32'hCAFE_F00D, 0, 2, 15, 32'hCAFE_F00D};
    v[10] = '{0, 2'd2, 0, 64, 0, 0, 1, 1, 15, 32'hCAFE_F00D};
    v[11] = '{1, 2'd1, 0, 63, 32'h1111, 0, 1, 1, 15, 32'hCAFE_F00D};
    v[12] = '{1, 2'd1, 0, 62, 32'hBEEF, 0, 0, 3, 15, 32'hCAFE_BEEF};
    v[13] = '{1, 2'd0, 0, 63, 32'h01, 0, 0, 3, 15, 32'hCAFE_BE01};
    v[14] = '{0, 2'd3, 0, 0, 0, 0, 1, 1, 0, 32'd0};
    v[15] = '{1, 2'd2, 0, 4, 32'h1234_5678, 0, 0, 2, 1, 32'h1234_5678};
    v[16] = '{0, 2'd0, 0, 64, 0, 0, 1, 1, 0, 32'd0};
    v[17] = '{1, 2'd1, 0, 0, 32'hFFFF_ABCD, 0, 0, 3, 0, 32'hABCD_0000};
    v[18] = '{0, 2'd1, 1, 62, 0, 32'hFFFF_BE01, 0, 2, 15, 32'hCAFE_BE01};

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    chk_rst("reset");
    Reset   = 1'b1;
    preload = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 19; i++) begin
      xact(v[i].we, v[i].sz, v[i].sg, v[i].a, v[i].wd,
           rd, er, lat, wec);
      chk($sformatf("v%0d rdata", i), rd, v[i].rd);
      chk($sformatf("v%0d err", i), {31'd0, er}, {31'd0, v[i].er});
      chk($sformatf("v%0d lat", i), 32'(lat), 32'(v[i].lat));
      chk($sformatf("v%0d we_cycles", i), 32'(wec),
          (v[i].we && !v[i].er) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d mem", i), mem[v[i].idx], v[i].mw);
    end

    // response fields hold after the pulse
    xact(0, 2'd2, 0, 8, 0, rd, er, lat, wec);
    repeat (3) @(posedge CLK);
    #1;
    chk("hold rdata", bus.resp_rdata, 32'h80FF_AA34);
    chk("hold rvalid", {31'd0, bus.resp_valid}, 32'd0);

    // reset while in RMW of a byte store
    drive(1, 2'd0, 0, 8, 32'h55);
    #1 Reset = 1'b0;
    #1 chk_rst("rmw reset");
    @(negedge CLK);
    @(posedge CLK); #1;
    chk("rmw reset mem", mem[2], 32'h80FF_AA34);
    Reset = 1'b1;
    @(posedge CLK); #1;
    xact(0, 2'd0, 0, 10, 0, rd, er, lat, wec);
    chk("after rmw reset rdata", rd, 32'h0000_00AA);
    chk("after rmw reset lat", 32'(lat), 32'd2);

    // reset in WRITE before the negedge suppresses the write
    drive(1, 2'd2, 0, 16, 32'h5A5A_5A5A);
    chk("write mwe", {31'd0, bus.mem_we}, 32'd1);
    #1 Reset = 1'b0;
    #1 chk("write reset mwe", {31'd0, bus.mem_we}, 32'd0);
    @(negedge CLK);
    @(posedge CLK); #1;
    chk("write reset mem", mem[4], 32'd0);
    Reset = 1'b1;
    @(posedge CLK); #1;
    xact(0, 2'd2, 0, 16, 0, rd, er, lat, wec);
    chk("after write reset rdata", rd, 32'd0);
    chk("after write reset err", {31'd0, er}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
